// File: rtl/result_accumulator_pkg.sv
// Shared definitions for the result accumulator.
// Holds the default widths and the control state encoding used by the
// top level and visible on its debug output.
package result_accumulator_pkg;

  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_add.sv
// Combinational unsigned adder with carry out.
// Ports:
//   a_i, b_i  : W-bit operands
//   sum_o     : low W bits of a_i + b_i
//   carry_o   : carry out of bit W-1 (sum did not fit in W bits)
module acc_add #(
  parameter int W = 40
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] sum_o,
  output logic         carry_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};

endmodule

// File: rtl/result_accumulator.sv
// Frame accumulator: sums frame_len consecutive input results into one
// saturating ACC_W-bit frame sum and offers it downstream.
// Ports:
//   clk, nrst                   : clock, asynchronous active-low reset
//   in_valid/in_ready/in_data   : input stream
//   frame_len                   : samples per frame (0 = 2^CNT_W), taken
//                                 on the first sample of each frame
//   clear                       : synchronous abort of the current frame
//   out_valid/out_ready/out_data/out_ovf : frame result stream
//   busy                        : frame in progress or result pending
//   dbg_state                   : current control state (state_t encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, and out_data/out_ovf stay
// stable while out_valid is high and out_ready is low.
module result_accumulator
  import result_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             in_valid,
  input  logic [ACC_W-1:0] in_data,
  output logic             in_ready,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             clear,
  output logic             out_valid,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  input  logic             out_ready,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W:0]   cnt_q, cnt_d;
  logic [CNT_W:0]   len_q, len_d;
  logic             ovf_q, ovf_d;

  logic             in_fire;
  logic             out_fire;
  logic [CNT_W:0]   len_in;
  logic [CNT_W:0]   cnt_inc;
  logic [ACC_W-1:0] add_sum;
  logic             add_carry;

  acc_add #(.W(ACC_W)) u_add (
    .a_i     (acc_q),
    .b_i     (in_data),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = acc_q;
  assign out_ovf   = ovf_q;
  assign dbg_state = state_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign cnt_inc  = cnt_q + CNT_ONE;

  // A zero length field stands for 2^CNT_W, which needs the extra bit.
  assign len_in = (frame_len == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, frame_len};

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            acc_d   = in_data;
            cnt_d   = CNT_ONE;
            len_d   = len_in;
            ovf_d   = 1'b0;
            state_d = (len_in == CNT_ONE) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            // Once the sum has overflowed it stays pinned at all ones.
            acc_d = (add_carry || ovf_q) ? '1 : add_sum;
            ovf_d = ovf_q | add_carry;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (out_fire) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_result_accumulator.sv
// Bench for result_accumulator: directed scenarios plus random frames,
// each expected frame sum computed by plain arithmetic on the samples.
module tb_result_accumulator;

  localparam int ACC_W = 40;
  localparam int CNT_W = 8;
  localparam logic [ACC_W-1:0] MAX = {ACC_W{1'b1}};

  logic             clk;
  logic             nrst;
  logic             in_valid;
  logic [ACC_W-1:0] in_data;
  logic             in_ready;
  logic [CNT_W-1:0] frame_len;
  logic             clear;
  logic             out_valid;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;
  logic             out_ready;
  logic             busy;
  logic [1:0]       dbg_state;

  int tests;
  int failed;

  logic [ACC_W-1:0] stim_q[$];
  logic [ACC_W-1:0] exp_q[$];
  logic             exp_ovf_q[$];

  result_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .frame_len (frame_len),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ovf   (out_ovf),
    .out_ready (out_ready),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Helpers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ACC_W-1:0] rand_data(input bit big);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    if (big) return r[ACC_W-1:0] | {2'b11, {(ACC_W-2){1'b0}}};
    return {{(ACC_W-16){1'b0}}, r[15:0]};
  endfunction

  // Driver: one input sample, waiting a bounded time for in_ready.
  task automatic send_sample(input logic [ACC_W-1:0] d);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && guard < 20) begin
      step();
      guard++;
    end
    check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
  endtask

  // Drives the samples in stim_q as one frame, then checks the result,
  // holding out_ready low for 'delay' cycles first.
  task automatic run_frame(input logic [CNT_W-1:0] len_field, input int delay, input bit gaps);
    logic [63:0]      total;
    logic [ACC_W-1:0] exp_sum;
    logic             exp_ovf;
    int               n;
    n     = stim_q.size();
    total = 64'd0;
    foreach (stim_q[i]) total += {{(64-ACC_W){1'b0}}, stim_q[i]};
    exp_ovf = (total > {{(64-ACC_W){1'b0}}, MAX});
    exp_sum = exp_ovf ? MAX : total[ACC_W-1:0];
    exp_q.push_back(exp_sum);
    exp_ovf_q.push_back(exp_ovf);

    out_ready = (delay == 0);
    frame_len = len_field;
    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) repeat ($urandom_range(0, 2)) step();
      send_sample(stim_q[i]);
      // Later length changes must not affect the frame in flight.
      if (i == 0) frame_len = CNT_W'($urandom());
      if (i < n - 1) check("mid_frame_no_out", {63'd0, out_valid}, 64'd0);
    end

    check("out_valid", {63'd0, out_valid}, 64'd1);
    check("out_data", {24'd0, out_data}, {24'd0, exp_q[0]});
    check("out_ovf", {63'd0, out_ovf}, {63'd0, exp_ovf_q[0]});
    check("done_in_ready", {63'd0, in_ready}, 64'd0);
    check("done_busy", {63'd0, busy}, 64'd1);

    for (int k = 0; k < delay; k++) begin
      in_valid = 1'b1;
      in_data  = rand_data(1'b0);
      step();
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_data", {24'd0, out_data}, {24'd0, exp_q[0]});
      check("hold_ovf", {63'd0, out_ovf}, {63'd0, exp_ovf_q[0]});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("after_out_valid", {63'd0, out_valid}, 64'd0);
    check("after_in_ready", {63'd0, in_ready}, 64'd1);
    check("after_busy", {63'd0, busy}, 64'd0);
    void'(exp_q.pop_front());
    void'(exp_ovf_q.pop_front());
    out_ready = 1'b0;
    stim_q.delete();
  endtask

  // Stimulus
  initial begin
    int len;
    tests     = 0;
    failed    = 0;
    nrst      = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    frame_len = '0;
    clear     = 1'b0;
    out_ready = 1'b0;

    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_data", {24'd0, out_data}, 64'd0);
    #5 nrst = 1'b1;
    step();

    // Single-sample frame.
    stim_q.push_back(40'h5);
    run_frame(8'd1, 0, 1'b0);

    // Four back-to-back samples, downstream always ready.
    for (int i = 1; i <= 4; i++) stim_q.push_back(ACC_W'(i));
    run_frame(8'd4, 0, 1'b0);

    // Saturation, then a clean frame clears the flag.
    stim_q.push_back(40'hFF_FFFF_FFFF);
    stim_q.push_back(40'h1);
    run_frame(8'd2, 0, 1'b0);
    stim_q.push_back(40'h3);
    run_frame(8'd1, 0, 1'b0);

    // Backpressure for 5 cycles.
    stim_q.push_back(40'h7);
    stim_q.push_back(40'h8);
    run_frame(8'd2, 5, 1'b0);

    // Clear after 2 of 4 samples.
    frame_len = 8'd4;
    send_sample(40'h11);
    send_sample(40'h22);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("clear_busy", {63'd0, busy}, 64'd0);
    check("clear_out_valid", {63'd0, out_valid}, 64'd0);
    check("clear_acc", {24'd0, out_data}, 64'd0);
    repeat (3) step();
    check("clear_idle_stays", {63'd0, out_valid}, 64'd0);

    // Asynchronous reset between edges after 2 of 4 samples.
    frame_len = 8'd4;
    send_sample(40'h33);
    send_sample(40'h44);
    nrst = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    check("arst_acc", {24'd0, out_data}, 64'd0);
    #1 nrst = 1'b1;
    for (int i = 0; i < 3; i++) stim_q.push_back(ACC_W'(10 + i));
    run_frame(8'd3, 1, 1'b0);

    // Clear while a result is pending discards it.
    stim_q.push_back(40'h9);
    frame_len = 8'd1;
    send_sample(40'h9);
    stim_q.delete();
    check("pend_out_valid", {63'd0, out_valid}, 64'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check("pend_discarded", {63'd0, out_valid}, 64'd0);
    check("pend_in_ready", {63'd0, in_ready}, 64'd1);

    // Length field 0 means 256 samples.
    for (int i = 0; i < 256; i++) stim_q.push_back(40'h1);
    run_frame(8'd0, 0, 1'b0);

    // Random frames with gaps, backpressure and occasional overflow.
    for (int f = 0; f < 20; f++) begin
      bit big;
      len = $urandom_range(1, 6);
      big = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) stim_q.push_back(rand_data(big));
      run_frame(CNT_W'(len), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/result_accumulator.md
RESULT_ACCUMULATOR -- requirements
Module: result_accumulator

Interface
REQ-001 Parameter: ACC_W, default 40, width of the incoming result and of the accumulator.
REQ-002 Parameter: CNT_W, default 8, width of the frame-length and sample counters.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: nrst  input  1  reset, asynchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream adder result valid this cycle.
REQ-006 Port: in_data  input  ACC_W  upstream 40-bit result (zero-extended 32-bit sum).
REQ-007 Port: in_ready  output  1  block accepts in_data this cycle.
REQ-008 Port: frame_len  input  CNT_W  samples per frame; sampled on the first accepted sample of a frame; 0 means 2^CNT_W.
REQ-009 Port: clear  input  1  synchronous abort of the current frame.
REQ-010 Port: out_valid  output  1  frame sum available.
REQ-011 Port: out_data  output  ACC_W  frame sum.
REQ-012 Port: out_ovf  output  1  sum saturated during this frame; valid only with out_valid.
REQ-013 Port: out_ready  input  1  downstream accepts out_data.
REQ-014 Port: busy  output  1  high in ACCUM or DONE.

Function
REQ-015 The block SHALL implement three states: IDLE, ACCUM and DONE.
REQ-016 A transfer SHALL occur on a rising edge where in_valid and in_ready are both high; likewise for out_valid and out_ready.
REQ-017 in_ready SHALL be high in IDLE and ACCUM and low in DONE.
REQ-018 In IDLE, an input transfer SHALL load acc = in_data, set cnt = 1, latch frame_len and clear the overflow flag; the next state SHALL be DONE if the latched length is 1, else ACCUM.
REQ-019 In ACCUM, each input transfer SHALL set acc = acc + in_data and cnt = cnt + 1; when the incremented cnt equals the latched length, the next state SHALL be DONE.
REQ-020 The addition SHALL be unsigned at ACC_W+1 bits; on carry out, acc SHALL saturate to all ones and the sticky overflow flag SHALL set until the next frame starts.
REQ-021 Once acc is saturated, further additions SHALL keep it saturated.
REQ-022 out_valid SHALL be high exactly in DONE, asserting the cycle after the last sample transfer (latency 1 cycle).
REQ-023 out_data and out_ovf SHALL be held stable while out_valid is high and out_ready is low.
REQ-024 In DONE, an output transfer SHALL return the block to IDLE, with no input accepted in that cycle.
REQ-025 clear high SHALL force IDLE, acc = 0, cnt = 0 and the overflow flag = 0 on the next edge, with priority over all transfers; any pending output SHALL be discarded.
REQ-026 in_valid without a transfer SHALL leave all state unchanged.
REQ-027 frame_len changes after the first sample of a frame SHALL NOT affect that frame.
REQ-028 cnt SHALL be CNT_W+1 bits wide so that a length of 2^CNT_W is reachable without wrap.

Reset
REQ-029 nrst low SHALL immediately force IDLE, acc = 0, cnt = 0, overflow flag = 0, out_valid = 0, busy = 0 and in_ready = 1, independent of clk.
REQ-030 Reset asserted mid-frame SHALL discard the partial sum; the first transfer after release SHALL start a new frame.

Structure
REQ-031 A shared package SHALL hold ACC_W, CNT_W defaults and the state enumeration (IDLE, ACCUM, DONE).
REQ-032 The adder SHALL be one sub-module, acc_add: combinational ACC_W-bit adder with carry out, the only instance.
REQ-033 All state SHALL be in result_accumulator; no latches, and one clock domain only.

Verification
REQ-034 Single-sample frame: frame_len=1, in_data=0x00_0000_0005 -> out_valid next cycle, out_data=0x5, out_ovf=0.
REQ-035 Four-sample frame: frame_len=4, data 1,2,3,4 back-to-back, out_ready=1 -> out_data=0xA one cycle after the 4th sample; in_ready low for exactly one cycle.
REQ-036 Saturation: frame_len=2, data 0xFF_FFFF_FFFF then 0x1 -> out_data=0xFF_FFFF_FFFF, out_ovf=1; next frame of 1 sample 0x3 -> out_ovf=0.
REQ-037 Backpressure: frame_len=2, data 7,8, out_ready low 5 cycles -> out_data=0xF stable, in_ready=0 throughout; IDLE after release.
REQ-038 Abort and reset: clear after 2 of 4 samples -> IDLE, no out_valid; repeat with nrst pulsed between clock edges -> outputs reset asynchronously, next frame sums correctly.
REQ-039 frame_len=0 with 256 samples of 0x1 -> out_data=0x100 after the 256th transfer.
